// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencing controller for an N-bit up-counter.
// Owns the count register and provides start/pause/resume/abort control,
// a programmable terminal count, one-shot or periodic operation and
// terminal-count/done signalling.
// Optional build macro COUNTER_SEQ_PRESCALE_EN adds a ps_div port and a
// psBits prescaler that slows the count rate to one tick per (ps_div+1)
// RUN cycles. Without the macro the counter ticks on every RUN cycle.
module counter_seq_ctrl #(
  parameter int nBits  = 16,
  parameter int psBits = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
`ifdef COUNTER_SEQ_PRESCALE_EN
  input  logic [psBits-1:0] ps_div,
`endif
  input  logic [nBits-1:0] limit,
  output logic [nBits-1:0] count,
  output logic             cnt_en,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [nBits-1:0] limit_q;
  logic             periodic_q;
  logic             tick;
  logic             adv;
  logic             terminal;
  logic             launch;

  // A fresh run is launched only from IDLE/DONE, and stop vetoes it.
  assign launch = ((state_q == IDLE) || (state_q == DONE)) && start && !stop;

`ifdef COUNTER_SEQ_PRESCALE_EN
  logic [psBits-1:0] ps_q;

  assign tick = (ps_q == ps_div);

  // Prescaler: free-runs only while RUN (and not being paused this cycle),
  // reloading to zero on each tick; cleared on launch and on abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q <= '0;
    end else if (launch) begin
      ps_q <= '0;
    end else if (state_q == RUN && !stop) begin
      if (tick) ps_q <= '0;
      else      ps_q <= ps_q + 1'b1;
    end else if (state_q == PAUSE && stop) begin
      ps_q <= '0;
    end
  end
`else
  // No prescaler: every RUN cycle is a tick (psBits has no effect here).
  assign tick = (psBits > 0) | 1'b1;
`endif

  assign cnt_en   = (state_q == RUN) & tick;
  // stop in RUN freezes the count even when a tick is due.
  assign adv      = cnt_en & ~stop;
  // Exact-width compare, so limit = all-ones wraps cleanly with no overflow.
  assign terminal = adv & (count == limit_q);

  assign busy = (state_q == RUN) || (state_q == PAUSE);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; stop takes priority over start in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (launch) state_d = RUN;
      end
      RUN: begin
        if (stop)                         state_d = PAUSE;
        else if (terminal && !periodic_q) state_d = DONE;
      end
      PAUSE: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Run configuration: limit and mode are captured only on a fresh launch,
  // so resume from PAUSE keeps the original settings.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      limit_q    <= '0;
      periodic_q <= 1'b0;
    end else if (launch) begin
      limit_q    <= limit;
      periodic_q <= periodic;
    end
  end

  // Count register: cleared on launch, terminal count and abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (launch) begin
      count <= '0;
    end else if (terminal) begin
      count <= '0;
    end else if (adv) begin
      count <= count + 1'b1;
    end else if (state_q == PAUSE && stop) begin
      count <= '0;
    end
  end

  // Terminal-count pulse, registered so it is high for exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tc <= 1'b0;
    else      tc <= terminal;
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencing controller for an N-bit up-counter datapath.
- Owns the count register and drives a count-enable strobe.
- Provides start/pause/resume/abort control, a programmable terminal count, one-shot or periodic operation, and terminal-count/done signalling.
- Sits between software-visible control bits and any logic that needs timed intervals built on the counter.

Parameters:
- nBits, 16, width of count and limit.
- psBits, 8, prescaler width; used only when PRESCALE_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  start from IDLE/DONE; resume from PAUSE.
- stop  input  1  pause from RUN; abort from PAUSE.
- periodic  input  1  mode select, latched on start from IDLE/DONE (1 = auto-reload).
- limit  input  nBits  terminal count, latched on start from IDLE/DONE.
- ps_div  input  psBits  prescale divisor; port present only with PRESCALE_EN.
- count  output  nBits  current count value.
- cnt_en  output  1  count-enable strobe; high in cycles where count advances.
- tc  output  1  registered one-cycle pulse on terminal count.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  high in DONE (one-shot complete).

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, limit_q=0, periodic_q=0, tc=0. busy=0, done=0, cnt_en=0; prescaler=0 if present.
- States: IDLE, RUN, PAUSE, DONE. Encoding is free; 2-bit binary is acceptable.
- IDLE/DONE + start:
  - limit_q<=limit, periodic_q<=periodic, count<=0, next state RUN.
  - First increment happens on the following cycle.
- tick is internal: 1 every RUN cycle without the option.
- cnt_en = (state==RUN) & tick, combinational.
- RUN, cnt_en=1, count!=limit_q: count<=count+1.
- RUN, cnt_en=1, count==limit_q:
  - count<=0 and tc<=1 for exactly one cycle.
  - periodic_q=1: stay in RUN. periodic_q=0: go to DONE.
- Period between tc pulses is (limit_q+1) ticks.
  - limit_q=0 gives tc on every tick.
  - limit_q=2^nBits-1 gives a full-range wrap with no overflow beyond nBits; the comparison is exact-width.
- RUN + stop: go to PAUSE, count held; no increment in that cycle (stop has priority over the tick).
- PAUSE + start: back to RUN. count, limit_q and periodic_q are kept; limit/periodic inputs are ignored.
- PAUSE + stop: abort to IDLE with count<=0.
- start and stop asserted together: stop wins in every state.
  - In IDLE/DONE both are ignored; stop alone in IDLE/DONE is also ignored.
- RUN + start (no stop): ignored; no restart.
- DONE holds count=0 and done=1 until the next start. done drops in the cycle after start is sampled.
- tc is 0 in every cycle other than the cycle after a terminal-count edge.
- Asynchronous reset mid-RUN returns all state immediately; any pending tc is discarded.
- Inputs are synchronous to clk; synchronizing them is not this block's job.

Optional Feature:
- Macro: COUNTER_SEQ_PRESCALE_EN
- Defined:
  - Port ps_div exists.
  - A psBits prescaler runs only in RUN. tick=1 when prescaler==ps_div, and the prescaler then reloads 0; otherwise it increments.
  - The prescaler clears on start from IDLE/DONE and on abort. It holds in PAUSE.
  - ps_div=0 gives a tick every cycle, identical to the macro undefined.
- Undefined:
  - No ps_div port and no prescaler logic.
  - tick=1 constantly in RUN.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> count=0, state IDLE, busy=0, done=0, tc=0; release -> no activity until start is sampled after release.
- One-shot: limit=5, periodic=0, pulse start -> count 0,1,2,3,4,5, then tc=1 for one cycle, count=0, done=1, busy=0; count stays 0 for 20 more cycles.
- Periodic wrap: nBits=4, limit=15, periodic=1 -> tc every 16 cycles for 3 periods; count never exceeds 15; busy stays 1.
- Pause/resume/abort: limit=10, stop at count=4 -> count holds 4 for 5 cycles; start -> resumes to 5; stop, stop -> IDLE, count=0.
- Simultaneous and ignored events: start&stop in RUN -> PAUSE; start in RUN -> no restart; limit=0 periodic -> tc on every cycle of RUN.
- PRESCALE_EN: ps_div=3, limit=2 -> count advances every 4 cycles; tc every 12 cycles; cnt_en high 1 of every 4 RUN cycles.
